// File: rtl/gmux_sel_ctrl.sv
// gmux_sel_ctrl: glitch-free select sequencer for one GMUX instance.
// Gates the outgoing source, flips IS0, settles, then enables the new one.
module gmux_sel_ctrl #(
  parameter int unsigned GATE_CYCLES   = 4,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic QCK,
  input  logic QRT,
  input  logic REQ,
  output logic IS0,
  output logic IP_EN,
  output logic IC_EN,
  output logic BUSY,
  output logic DONE
);

  typedef enum logic [1:0] {
    IDLE,
    GATE,
    SETTLE
  } state_t;

  localparam logic [7:0] GLOAD = 8'(GATE_CYCLES - 1);
  localparam logic [7:0] SLOAD = 8'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [7:0] cnt;
  logic       req_m;
  logic       req_s;

  // REQ may be asynchronous to QCK
  always_ff @(posedge QCK or posedge QRT) begin
    if (QRT) begin
      req_m <= 1'b0;
      req_s <= 1'b0;
    end else begin
      req_m <= REQ;
      req_s <= req_m;
    end
  end

  always_ff @(posedge QCK or posedge QRT) begin
    if (QRT) begin
      state <= IDLE;
      cnt   <= 8'd0;
      IS0   <= 1'b0;
      IP_EN <= 1'b1;
      IC_EN <= 1'b0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      DONE <= 1'b0;
      unique case (state)
        IDLE: begin
          IP_EN <= ~IS0;
          IC_EN <= IS0;
          BUSY  <= 1'b0;
          if (req_s != IS0) begin
            state <= GATE;
            IP_EN <= 1'b0;
            IC_EN <= 1'b0;
            BUSY  <= 1'b1;
            cnt   <= GLOAD;
          end
        end
        GATE: begin
          IP_EN <= 1'b0;
          IC_EN <= 1'b0;
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else begin
            IS0   <= ~IS0;
            cnt   <= SLOAD;
            state <= SETTLE;
          end
        end
        SETTLE: begin
          IP_EN <= 1'b0;
          IC_EN <= 1'b0;
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else begin
            // IS0 already holds the new source here
            IP_EN <= ~IS0;
            IC_EN <= IS0;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 8'd0;
          IS0   <= 1'b0;
          IP_EN <= 1'b1;
          IC_EN <= 1'b0;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gmux_sel_ctrl.sv
// tb_gmux_sel_ctrl: three sequencers (4/2, 1/1, 255/255) against a
// timeline model; directed REQ vectors with literal checks on 4/2.
module tb_gmux_sel_ctrl;

  logic QCK;
  logic QRT;
  logic REQ;
  logic [2:0] is0, ip, ic, busy, done;

  gmux_sel_ctrl #(.GATE_CYCLES(4), .SETTLE_CYCLES(2)) u0 (
    .QCK(QCK), .QRT(QRT), .REQ(REQ),
    .IS0(is0[0]), .IP_EN(ip[0]), .IC_EN(ic[0]),
    .BUSY(busy[0]), .DONE(done[0])
  );
  gmux_sel_ctrl #(.GATE_CYCLES(1), .SETTLE_CYCLES(1)) u1 (
    .QCK(QCK), .QRT(QRT), .REQ(REQ),
    .IS0(is0[1]), .IP_EN(ip[1]), .IC_EN(ic[1]),
    .BUSY(busy[1]), .DONE(done[1])
  );
  gmux_sel_ctrl #(.GATE_CYCLES(255), .SETTLE_CYCLES(255)) u2 (
    .QCK(QCK), .QRT(QRT), .REQ(REQ),
    .IS0(is0[2]), .IP_EN(ip[2]), .IC_EN(ic[2]),
    .BUSY(busy[2]), .DONE(done[2])
  );

  initial QCK = 1'b0;
  always #5 QCK = ~QCK;

  int total = 0;
  int bad = 0;

  function automatic int gc(input int i);
    return (i == 0) ? 4 : (i == 1) ? 1 : 255;
  endfunction
  function automatic int sc(input int i);
    return (i == 0) ? 2 : (i == 1) ? 1 : 255;
  endfunction

  // timeline model: outputs are a function of edges since the switch began
  logic m_s1 [3];
  logic m_s2 [3];
  logic m_act [3];
  logic m_old [3];
  logic m_sel [3];
  logic m_ip [3];
  logic m_ic [3];
  logic m_busy [3];
  logic m_done [3];
  int   m_t0 [3];
  int   cyc;

  always @(posedge QCK or posedge QRT) begin
    if (QRT) begin
      cyc = 0;
      for (int i = 0; i < 3; i++) begin
        m_s1[i] = 0; m_s2[i] = 0; m_act[i] = 0; m_old[i] = 0;
        m_sel[i] = 0; m_ip[i] = 1; m_ic[i] = 0;
        m_busy[i] = 0; m_done[i] = 0; m_t0[i] = 0;
      end
    end else begin
      cyc = cyc + 1;
      for (int i = 0; i < 3; i++) begin
        int e;
        m_done[i] = 0;
        if (!m_act[i] && m_s2[i] != m_sel[i]) begin
          m_act[i] = 1;
          m_t0[i] = cyc;
          m_old[i] = m_sel[i];
        end
        if (m_act[i]) begin
          e = cyc - m_t0[i];
          m_sel[i] = (e >= gc(i)) ? ~m_old[i] : m_old[i];
          m_busy[i] = 1; m_ip[i] = 0; m_ic[i] = 0;
          if (e == gc(i) + sc(i)) begin
            m_busy[i] = 0; m_done[i] = 1; m_act[i] = 0;
            m_ip[i] = ~m_sel[i]; m_ic[i] = m_sel[i];
          end
        end else begin
          m_ip[i] = ~m_sel[i]; m_ic[i] = m_sel[i]; m_busy[i] = 0;
        end
        m_s2[i] = m_s1[i];
        m_s1[i] = REQ;
      end
    end
  end

  function automatic logic [4:0] db(input int i);
    return {is0[i], ip[i], ic[i], busy[i], done[i]};
  endfunction
  function automatic logic [4:0] mb(input int i);
    return {m_sel[i], m_ip[i], m_ic[i], m_busy[i], m_done[i]};
  endfunction

  logic [2:0] p_is0, p_en;
  logic p_ok = 1'b0;

  always @(negedge QCK) begin
    if (QRT) begin
      p_ok = 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (db(i) !== mb(i)) begin
          bad++;
          $display("FAIL model dut%0d t=%0t got=%b want=%b",
                   i, $time, db(i), mb(i));
        end
        total++;
        if (ip[i] && ic[i]) begin
          bad++;
          $display("FAIL both_en dut%0d t=%0t got=11 want=not 11", i, $time);
        end
        if (p_ok) begin
          total++;
          if (is0[i] != p_is0[i] && (p_en[i] || ip[i] || ic[i])) begin
            bad++;
            $display("FAIL is0_while_en dut%0d t=%0t is0 %b->%b en=%b%b",
                     i, $time, p_is0[i], is0[i], ip[i], ic[i]);
          end
        end
        p_is0[i] = is0[i];
        p_en[i]  = ip[i] | ic[i];
      end
      p_ok = 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [4:0] want);
    total++;
    if (db(0) !== want) begin
      bad++;
      $display("FAIL %s dut got=%b want=%b", nm, db(0), want);
    end
    total++;
    if (mb(0) !== want) begin
      bad++;
      $display("FAIL %s model got=%b want=%b", nm, mb(0), want);
    end
  endtask

  task automatic chki(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(negedge QCK);
  endtask

  // edges from the REQ change to DONE on each instance
  task automatic latency(input string nm, input logic v);
    int l0, l1, l2;
    l0 = -1; l1 = -1; l2 = -1;
    REQ = v;
    for (int n = 1; n <= 1000; n++) begin
      @(negedge QCK);
      if (done[0] && l0 < 0) l0 = n;
      if (done[1] && l1 < 0) l1 = n;
      if (done[2] && l2 < 0) l2 = n;
      if (l0 >= 0 && l1 >= 0 && l2 >= 0) break;
    end
    chki({nm, "_g4s2"}, l0, 9);
    chki({nm, "_g1s1"}, l1, 5);
    chki({nm, "_g255s255"}, l2, 513);
  endtask

  logic seen;

  initial begin
    QRT = 1'b1;
    REQ = 1'b0;
    #1;
    chk("reset_async", 5'b01000);
    edges(2);
    #2 QRT = 1'b0;
    edges(20);
    chk("idle20", 5'b01000);

    // IP -> IC
    @(negedge QCK);
    REQ = 1'b1;
    edges(3); chk("up_e3", 5'b00010);
    edges(3); chk("up_e6", 5'b00010);
    edges(1); chk("up_e7", 5'b10010);
    edges(2); chk("up_e9", 5'b10101);
    edges(1); chk("up_e10", 5'b10100);
    edges(600);

    // IC -> IP
    REQ = 1'b0;
    edges(3); chk("dn_e3", 5'b10010);
    edges(4); chk("dn_e7", 5'b00010);
    edges(2); chk("dn_e9", 5'b01001);
    edges(1); chk("dn_e10", 5'b01000);
    edges(600);

    // REQ reverts during GATE
    REQ = 1'b1;
    edges(4);
    REQ = 1'b0;
    edges(5); chk("mid_e9", 5'b10101);
    edges(1); chk("mid_e10", 5'b10010);
    edges(4); chk("mid_e14", 5'b00010);
    edges(2); chk("mid_e16", 5'b01001);
    edges(600);

    // reset while in SETTLE
    REQ = 1'b1;
    edges(8);
    #2 QRT = 1'b1;
    #1 chk("rst_mid", 5'b01000);
    REQ = 1'b0;
    edges(2);
    #2 QRT = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(negedge QCK);
      seen = seen | done[0];
    end
    chki("rst_mid_nodone", int'(seen), 0);
    chk("rst_mid_after", 5'b01000);

    // extremes latency, both directions
    latency("lat_up", 1'b1);
    edges(20);
    latency("lat_dn", 1'b0);
    edges(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gmux_sel_ctrl.md
# gmux_sel_ctrl

Glitch-free select sequencer for the global clock mux: it generates the GMUX select (IS0) plus gating enables for the two clock sources (IP and IC) feeding that mux. The sequencer stops the outgoing source before IS0 moves and holds the incoming source off until the mux has settled, so IZ never sees a runt pulse. It sits in the control clock domain next to each GMUX instance and is the driver of that mux's select pin. Its outputs go to the GMUX IS0 input and to the upstream clock-enable cells.

## Interface
- GATE_CYCLES, 4: cycles the outgoing source stays gated before IS0 flips; legal range 1..255.
- SETTLE_CYCLES, 2: cycles after the IS0 flip before the incoming source is enabled; legal range 1..255.
- QCK  in  1  control clock, rising-edge; the one clock of the block.
- QRT  in  1  reset, asynchronous, active-high.
- REQ  in  1  requested source: 0 = IP, 1 = IC; may be asynchronous to QCK.
- IS0  out 1  GMUX select: 0 = IP, 1 = IC.
- IP_EN  out 1  enable for the IP clock source.
- IC_EN  out 1  enable for the IC clock source.
- BUSY  out 1  high while a switch sequence is in progress.
- DONE  out 1  single-cycle pulse when a switch sequence completes.

## Operation
- REQ passes through a 2-flop synchronizer (reset value 0); REQ_S is the second flop.
- All outputs are registered and come straight from flops.
- 8-bit down-counter CNT.
- States: IDLE, GATE, SETTLE.
- IDLE:
  - Enable of the selected source = 1 (IP_EN = ~IS0, IC_EN = IS0); BUSY = 0.
  - If REQ_S != IS0: next state GATE. At that edge, clear the current source's enable, set BUSY = 1, load CNT = GATE_CYCLES-1.
- GATE:
  - Both enables = 0.
  - CNT != 0: decrement.
  - CNT == 0: at that edge, invert IS0, load CNT = SETTLE_CYCLES-1, go to SETTLE.
- SETTLE:
  - Both enables = 0.
  - CNT != 0: decrement.
  - CNT == 0: at that edge, set the enable of the new source (per the new IS0), BUSY = 0, DONE = 1, go to IDLE.
- DONE is high for exactly one cycle. It is otherwise 0.
- Target latching: the target is fixed when GATE is entered. REQ_S changes during GATE or SETTLE are ignored, and there is no abort.
- After completion: IDLE re-compares REQ_S against IS0 in the DONE cycle. If REQ reverted during the sequence, the next sequence starts at the following edge. The new enable is then high for exactly one cycle; this is legal.
- Invariant: IP_EN and IC_EN are never both 1. IS0 changes only while both enables are 0.
- Reset mid-sequence: all state returns to reset values immediately (IP selected and enabled). The sequence is not resumed.

## Timing
- Reset values: IS0 = 0, IP_EN = 1, IC_EN = 0, BUSY = 0, DONE = 0, state IDLE, CNT = 0, sync flops = 0.
- REQ pin change at edge k is seen as REQ_S after edge k+2.
- With the first IDLE cycle where REQ_S != IS0 taken as cycle n:
  - Old enable falls and BUSY rises after edge n+1.
  - IS0 flips after edge n+1+GATE_CYCLES.
  - New enable rises and DONE pulses after edge n+1+GATE_CYCLES+SETTLE_CYCLES.
- Both enables are low for GATE_CYCLES+SETTLE_CYCLES cycles.
- BUSY is high for GATE_CYCLES+SETTLE_CYCLES cycles, falling on the same edge DONE rises.
- A REQ glitch shorter than one QCK period may be missed. Only the sampled REQ_S value matters.

## Test plan
- Reset: assert QRT between clocks -> outputs take reset values immediately, without waiting for a QCK edge; after release, 20 idle cycles show no change.
- Switch IP→IC (G=4, S=2): REQ 0→1 -> after 3 edges IP_EN=0, BUSY=1; 4 cycles later IS0=1; 2 cycles later IC_EN=1, DONE=1 for one cycle, BUSY=0.
- Switch IC→IP: REQ 1→0 from the IC steady state -> mirror timing, ending with IP_EN=1, IS0=0.
- REQ change mid-sequence (G=4, S=2): REQ 0→1, then back to 0 during GATE -> first sequence completes to IS0=1; IC_EN=1 for one cycle (the DONE cycle); a second sequence then returns to IS0=0, IP_EN=1.
- Reset mid-sequence: assert QRT during SETTLE -> IS0=0, IP_EN=1, IC_EN=0, BUSY=0, and no DONE pulse.
- Extremes: G=1, S=1 and G=255, S=255, checking every cycle:
  - Enables are never both 1.
  - IS0 never toggles while either enable is 1.
  - Latency equals 3+G+S edges from the REQ change.
